// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: bit-serial MULT/MULTU/DIV/DIVU engine owning HI/LO.
// Ports: Start/Op/RsVal/RtVal launch an op; MtHi/MtLo/MtData write HI/LO;
//   IF_ID_ReadHiLo qualifies HiLo_Stall; Hi/Lo, Busy, Done, DivByZero out.
module muldiv_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] RsVal,
  input  logic [WIDTH-1:0] RtVal,
  input  logic             MtHi,
  input  logic             MtLo,
  input  logic [WIDTH-1:0] MtData,
  input  logic             IF_ID_ReadHiLo,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo,
  output logic             Busy,
  output logic             Done,
  output logic             DivByZero,
  output logic             HiLo_Stall
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t state;
  state_t state_nx;

  logic load;
  logic iter;
  logic commit;
  logic mt_hi_we;
  logic mt_lo_we;
  logic last;

  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic             is_div;
  logic             neg_q;
  logic             neg_r;
  logic             dz;

  logic             sgn_op;
  logic             rs_neg;
  logic             rt_neg;
  logic [WIDTH-1:0] rs_mag;
  logic [WIDTH-1:0] rt_mag;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   shifted;
  logic             borrow;
  logic [WIDTH-1:0] div_diff;

  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   res_hi;
  logic [WIDTH-1:0]   res_lo;

  assign last = (cnt == CNT_W'(WIDTH-1));

  assign Busy       = (state != IDLE);
  assign HiLo_Stall = IF_ID_ReadHiLo &
                      (Busy | (Start & (state == IDLE)));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    iter     = 1'b0;
    commit   = 1'b0;
    mt_hi_we = 1'b0;
    mt_lo_we = 1'b0;
    unique case (state)
      IDLE: begin
        if (Start) begin
          load     = 1'b1;
          state_nx = RUN;
        end else begin
          mt_hi_we = MtHi;
          mt_lo_we = MtLo;
        end
      end
      RUN: begin
        iter = 1'b1;
        if (last) begin
          state_nx = FIX;
        end
      end
      FIX: begin
        commit   = 1'b1;
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Op[0]==0 selects the signed flavour of both MULT and DIV.
  always_comb begin
    sgn_op = ~Op[0];
    rs_neg = sgn_op & RsVal[WIDTH-1];
    rt_neg = sgn_op & RtVal[WIDTH-1];
    rs_mag = rs_neg ? -RsVal : RsVal;
    rt_mag = rt_neg ? -RtVal : RtVal;
  end

  // Multiply: acc_lo holds the multiplier and fills with product bits
  // from the top as it shifts right.
  // Divide: acc_lo holds the dividend and fills with quotient bits.
  // Borrow compares at WIDTH+1 bits, so a zero divisor always
  // "subtracts", yielding all-ones quotient and the dividend in acc_hi.
  always_comb begin
    mul_sum  = {1'b0, acc_hi} +
               (acc_lo[0] ? {1'b0, b_reg} : '0);
    shifted  = {acc_hi, acc_lo[WIDTH-1]};
    borrow   = (shifted < {1'b0, b_reg});
    div_diff = shifted[WIDTH-1:0] - b_reg;
  end

  always_comb begin
    prod   = {acc_hi, acc_lo};
    res_hi = acc_hi;
    res_lo = acc_lo;
    if (is_div) begin
      res_hi = neg_r ? -acc_hi : acc_hi;
      res_lo = (neg_q & ~dz) ? -acc_lo : acc_lo;
    end else begin
      if (neg_q) begin
        prod = -prod;
      end
      res_hi = prod[2*WIDTH-1:WIDTH];
      res_lo = prod[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt    <= '0;
      b_reg  <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      dz     <= 1'b0;
    end else if (load) begin
      cnt    <= '0;
      is_div <= Op[1];
      neg_q  <= rs_neg ^ rt_neg;
      neg_r  <= Op[1] & rs_neg;
      dz     <= Op[1] & (RtVal == '0);
      acc_hi <= '0;
      if (Op[1]) begin
        acc_lo <= rs_mag;
        b_reg  <= rt_mag;
      end else begin
        acc_lo <= rt_mag;
        b_reg  <= rs_mag;
      end
    end else if (iter) begin
      cnt <= cnt + 1'b1;
      if (is_div) begin
        acc_hi <= borrow ? shifted[WIDTH-1:0] : div_diff;
        acc_lo <= {acc_lo[WIDTH-2:0], ~borrow};
      end else begin
        {acc_hi, acc_lo} <= {mul_sum, acc_lo[WIDTH-1:1]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      Hi        <= '0;
      Lo        <= '0;
      Done      <= 1'b0;
      DivByZero <= 1'b0;
    end else begin
      Done      <= commit;
      DivByZero <= commit & is_div & dz;
      if (commit) begin
        Hi <= res_hi;
        Lo <= res_lo;
      end else begin
        if (mt_hi_we) begin
          Hi <= MtData;
        end
        if (mt_lo_we) begin
          Lo <= MtData;
        end
      end
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: directed + random bench for muldiv_sequencer.
// Reference model computes HI/LO with plain 64-bit arithmetic.
module tb_muldiv_sequencer;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [1:0]    op = 2'b00;
  logic [W-1:0]  rs = '0;
  logic [W-1:0]  rt = '0;
  logic          mthi = 1'b0;
  logic          mtlo = 1'b0;
  logic [W-1:0]  mtdata = '0;
  logic          rd = 1'b0;
  logic [W-1:0]  hi;
  logic [W-1:0]  lo;
  logic          busy;
  logic          done;
  logic          dbz;
  logic          stall;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  muldiv_sequencer #(.WIDTH(W), .CNT_W(6)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .Start(start),
    .Op(op),
    .RsVal(rs),
    .RtVal(rt),
    .MtHi(mthi),
    .MtLo(mtlo),
    .MtData(mtdata),
    .IF_ID_ReadHiLo(rd),
    .Hi(hi),
    .Lo(lo),
    .Busy(busy),
    .Done(done),
    .DivByZero(dbz),
    .HiLo_Stall(stall)
  );

  always #5 clk = ~clk;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t",
               name, act, exp, $time);
    end
  endtask

  function automatic void ref_op(input logic [1:0] o,
                                 input logic [31:0] a,
                                 input logic [31:0] b,
                                 output logic [31:0] h,
                                 output logic [31:0] l,
                                 output logic z);
    int sa;
    int sb;
    longint sp;
    logic [63:0] up;
    sa = a;
    sb = b;
    z = 1'b0;
    h = '0;
    l = '0;
    case (o)
      2'b00: begin
        sp = longint'(sa) * longint'(sb);
        {h, l} = sp;
      end
      2'b01: begin
        up = {32'b0, a} * {32'b0, b};
        {h, l} = up;
      end
      2'b10: begin
        if (b == 0) begin
          h = a; l = '1; z = 1'b1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          h = '0; l = 32'h8000_0000;
        end else begin
          l = sa / sb;
          h = sa % sb;
        end
      end
      default: begin
        if (b == 0) begin
          h = a; l = '1; z = 1'b1;
        end else begin
          l = a / b;
          h = a % b;
        end
      end
    endcase
  endfunction

  // Model: an accepted op completes WIDTH+1 edges later.
  int          m_rem = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  logic        m_done = 1'b0;
  logic        m_dz = 1'b0;
  logic [31:0] p_hi = '0;
  logic [31:0] p_lo = '0;
  logic        p_dz = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_rem = 0; m_hi = '0; m_lo = '0;
      m_done = 1'b0; m_dz = 1'b0;
    end else begin
      m_done = 1'b0;
      m_dz = 1'b0;
      if (m_rem > 0) begin
        m_rem--;
        if (m_rem == 0) begin
          m_hi = p_hi; m_lo = p_lo;
          m_done = 1'b1; m_dz = p_dz;
        end
      end else if (start) begin
        ref_op(op, rs, rt, p_hi, p_lo, p_dz);
        m_rem = W + 1;
      end else begin
        if (mthi) m_hi = mtdata;
        if (mtlo) m_lo = mtdata;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", busy, m_rem > 0);
      check("hi", hi, m_hi);
      check("lo", lo, m_lo);
      check("done", done, m_done);
      check("divbyzero", dbz, m_dz);
      check("stall", stall, rd & ((m_rem > 0) | start));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input string name, input logic [1:0] o,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el,
                        input logic ez);
    int n;
    start = 1'b1; op = o; rs = a; rt = b;
    step();
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    n = 1;
    while (!done && n < 60) begin
      step();
      n++;
    end
    check({name, "_latency"}, n, 34);
    check({name, "_hi"}, hi, eh);
    check({name, "_lo"}, lo, el);
    check({name, "_dz"}, dbz, ez);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 9))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] th;
    logic [31:0] tl;
    logic        tz;
    int n;
    int dcount;

    ref_op(2'b00, 32'd7, 32'hFFFF_FFFD, th, tl, tz);
    check("model_mult_hi", th, 32'hFFFF_FFFF);
    check("model_mult_lo", tl, 32'hFFFF_FFEB);
    ref_op(2'b11, 32'd100, 32'd7, th, tl, tz);
    check("model_divu_hi", th, 32'd2);
    check("model_divu_lo", tl, 32'd14);
    ref_op(2'b10, 32'hFFFF_FFF9, 32'd2, th, tl, tz);
    check("model_div_hi", th, 32'hFFFF_FFFF);
    check("model_div_lo", tl, 32'hFFFF_FFFD);

    rst_n = 1'b0;
    step();
    chk_en = 1'b1;
    step();
    rst_n = 1'b1;
    check("rst_busy", busy, 1'b0);
    check("rst_hi", hi, 32'h0);
    check("rst_lo", lo, 32'h0);
    check("rst_done", done, 1'b0);
    check("rst_dz", dbz, 1'b0);

    run_op("mult", 2'b00, 32'd7, 32'hFFFF_FFFD,
           32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
    run_op("multu", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
           32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    run_op("divu", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
    run_op("div", 2'b10, 32'hFFFF_FFF9, 32'd2,
           32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_op("div0", 2'b10, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1);
    run_op("div0neg", 2'b10, 32'hFFFF_FFF9, 32'd0,
           32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1);
    run_op("divovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF,
           32'h0, 32'h8000_0000, 1'b0);
    step();
    check("dz_clear", dbz, 1'b0);
    check("done_clear", done, 1'b0);

    rd = 1'b1;
    start = 1'b1; op = 2'b00; rs = 32'd3; rt = 32'd5;
    #1;
    check("stall_c0", stall, 1'b1);
    step();
    start = 1'b0;
    n = 1;
    while (!done && n < 60) begin
      if (n == 10) begin
        start = 1'b1; op = 2'b11; rs = 32'd9; rt = 32'd2;
      end else begin
        start = 1'b0;
      end
      step();
      n++;
    end
    check("stall_latency", n, 34);
    check("stall_done_cycle", stall, 1'b0);
    check("ignore_hi", hi, 32'd0);
    check("ignore_lo", lo, 32'd15);
    rd = 1'b0;

    start = 1'b1; op = 2'b01; rs = 32'd11; rt = 32'd13;
    step();
    start = 1'b0;
    repeat (9) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("abort_busy", busy, 1'b0);
    check("abort_hi", hi, 32'h0);
    check("abort_lo", lo, 32'h0);
    dcount = 0;
    repeat (40) begin
      step();
      if (done) dcount++;
    end
    check("abort_no_done", dcount, 0);

    mthi = 1'b1; mtdata = 32'h1234;
    step();
    mthi = 1'b0;
    check("mthi_hi", hi, 32'h1234);
    check("mthi_lo", lo, 32'h0);
    mtlo = 1'b1; mthi = 1'b1; mtdata = 32'h55;
    step();
    mtlo = 1'b0; mthi = 1'b0;
    check("mtboth_hi", hi, 32'h55);
    check("mtboth_lo", lo, 32'h55);

    mtlo = 1'b1; mtdata = 32'hDEAD;
    run_op("mt_vs_start", 2'b01, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0);

    for (int i = 0; i < 6000; i++) begin
      start  = ($urandom_range(0, 5) == 0);
      op     = 2'($urandom_range(0, 3));
      rs     = pick();
      rt     = pick();
      mthi   = ($urandom_range(0, 3) == 0);
      mtlo   = ($urandom_range(0, 3) == 0);
      mtdata = $urandom;
      rd     = $urandom_range(0, 1) == 1;
      rst_n  = ($urandom_range(0, 499) != 0);
      step();
    end
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0; rst_n = 1'b1;
    repeat (40) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
